// File: rtl/coax_pkg.sv
// Shared coax definitions: packer FSM states, stream header bytes, receiver error codes.
package coax_pkg;

    localparam int unsigned WORD_W = 10;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [3:0] {
        IDLE,
        SEND_HI,
        SEND_LO,
        SETTLE,
        ERR_HI,
        ERR_LO,
        ERR_WAIT,
        EOM_HI,
        EOM_LO
    } pack_state_t;

    localparam logic [BYTE_W-1:0] HDR_DATA  = 8'h00;
    localparam logic [BYTE_W-1:0] HDR_ERROR = 8'hC0;
    localparam logic [BYTE_W-1:0] HDR_EOM   = 8'h80;

    localparam logic [WORD_W-1:0] ERROR_OVERFLOW = 10'b0000001000;

    // Header byte: marker/error flags in bits 7:6, payload bits 9:8 in bits 1:0.
    function automatic logic [BYTE_W-1:0] hdr_byte(input logic [BYTE_W-1:0] hdr,
                                                   input logic [WORD_W-1:0] payload);
        return hdr | {6'b000000, payload[9:8]};
    endfunction

endpackage

// File: rtl/coax_byte_out.sv
// Registered valid/ready byte holding register: load presents a byte, held until ready.
module coax_byte_out
    import coax_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [BYTE_W-1:0] load_data,
    input  logic              ready,
    output logic [BYTE_W-1:0] data,
    output logic              valid
);

    // A load in the same cycle as acceptance chains the next byte without a gap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/coax_rx_packer.sv
// Pops coax receiver FIFO words and serialises them as two-byte data/error/EOM pairs.
// Optional end-of-message pairs are enabled by defining COAX_RX_PACKER_EOM_EN.
module coax_rx_packer
    import coax_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_active,
    input  logic              rx_error,
    input  logic [WORD_W-1:0] rx_data,
    input  logic              rx_empty,
    output logic              rx_read_strobe,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    pack_state_t       state_q;
    pack_state_t       state_d;
    logic [BYTE_W-1:0] word_reg;
    logic [BYTE_W-1:0] err_reg;
    logic [CNT_W-1:0]  settle_cnt;

    logic              accept;
    logic              load;
    logic [BYTE_W-1:0] load_byte;
    logic              pop;
    logic              latch_word;
    logic              latch_err;

`ifdef COAX_RX_PACKER_EOM_EN
    logic              saw_active;
    logic [BYTE_W-1:0] word_count;
    logic              eom_done;
`else
    logic              unused_rx_active;
    assign unused_rx_active = rx_active;
`endif

    assign accept = out_valid && out_ready;

    // Next state and byte-load decisions; IDLE priority is error, data, then end-of-message.
    always_comb begin
        state_d    = state_q;
        load       = 1'b0;
        load_byte  = '0;
        pop        = 1'b0;
        latch_word = 1'b0;
        latch_err  = 1'b0;
`ifdef COAX_RX_PACKER_EOM_EN
        eom_done   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (rx_error) begin
                    latch_err = 1'b1;
                    load      = 1'b1;
                    load_byte = hdr_byte(HDR_ERROR, rx_data);
                    state_d   = ERR_HI;
                end else if (!rx_empty) begin
                    latch_word = 1'b1;
                    pop        = 1'b1;
                    load       = 1'b1;
                    load_byte  = hdr_byte(HDR_DATA, rx_data);
                    state_d    = SEND_HI;
`ifdef COAX_RX_PACKER_EOM_EN
                end else if (saw_active && !rx_active) begin
                    load      = 1'b1;
                    load_byte = HDR_EOM;
                    state_d   = EOM_HI;
`endif
                end
            end
            SEND_HI: begin
                if (accept) begin
                    load      = 1'b1;
                    load_byte = word_reg;
                    state_d   = SEND_LO;
                end
            end
            SEND_LO: begin
                if (accept) state_d = SETTLE;
            end
            SETTLE: begin
                if (settle_cnt == SETTLE_LAST) state_d = IDLE;
            end
            ERR_HI: begin
                if (accept) begin
                    load      = 1'b1;
                    load_byte = err_reg;
                    state_d   = ERR_LO;
                end
            end
            ERR_LO: begin
                if (accept) state_d = ERR_WAIT;
            end
            ERR_WAIT: begin
                if (!rx_error) state_d = IDLE;
            end
`ifdef COAX_RX_PACKER_EOM_EN
            EOM_HI: begin
                if (accept) begin
                    load      = 1'b1;
                    load_byte = word_count;
                    state_d   = EOM_LO;
                end
            end
            EOM_LO: begin
                if (accept) begin
                    eom_done = 1'b1;
                    state_d  = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State, pop strobe, payload latches and settle timer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            busy           <= 1'b0;
            rx_read_strobe <= 1'b0;
            word_reg       <= '0;
            err_reg        <= '0;
            settle_cnt     <= '0;
        end else begin
            state_q        <= state_d;
            busy           <= (state_d != IDLE);
            rx_read_strobe <= pop;
            if (latch_word) word_reg <= rx_data[7:0];
            if (latch_err)  err_reg  <= rx_data[7:0];
            if (state_q == SETTLE) settle_cnt <= settle_cnt + CNT_W'(1);
            else                   settle_cnt <= '0;
        end
    end

`ifdef COAX_RX_PACKER_EOM_EN
    // Message tracking: activity seen since last EOM, and words sent in this message.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            saw_active <= 1'b0;
            word_count <= '0;
        end else begin
            if (rx_active)     saw_active <= 1'b1;
            else if (eom_done) saw_active <= 1'b0;
            if (pop)           word_count <= word_count + 8'd1;
            else if (eom_done) word_count <= '0;
        end
    end
`endif

    coax_byte_out u_byte_out (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_data (load_byte),
        .ready     (out_ready),
        .data      (out_data),
        .valid     (out_valid)
    );

endmodule

// File: tb/tb_coax_rx_packer.sv
// Directed self-checking bench for coax_rx_packer with a queue-based FIFO model.
module tb_coax_rx_packer;
    import coax_pkg::*;

    logic       clk;
    logic       reset;
    logic       rx_active;
    logic       rx_error;
    logic [9:0] rx_data;
    logic       rx_empty;
    logic       rx_read_strobe;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int strobes  = 0;
    int strobe_cyc[$];
    logic [9:0] fifo_q[$];
    logic [7:0] got[$];

    typedef struct {
        logic [9:0] word;
        logic [7:0] exp_hi;
        logic [7:0] exp_lo;
    } vec_t;

    vec_t vecs[6];

    coax_rx_packer #(.SETTLE_CYCLES(1)) dut (
        .clk            (clk),
        .reset          (reset),
        .rx_active      (rx_active),
        .rx_error       (rx_error),
        .rx_data        (rx_data),
        .rx_empty       (rx_empty),
        .rx_read_strobe (rx_read_strobe),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: pop on strobe; head/empty update after the edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rx_read_strobe) begin
            strobes++;
            strobe_cyc.push_back(cyc);
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            rx_empty <= (fifo_q.size() == 0);
            if (fifo_q.size() > 0) rx_data <= fifo_q[0];
        end
    end

    always @(posedge clk) begin
        if (out_valid && out_ready) got.push_back(out_data);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] byte_at(input int i);
        if (i < got.size()) return {24'h0, got[i]};
        return 32'hFFFF_FFFF;
    endfunction

    task automatic push_word(input logic [9:0] w);
        fifo_q.push_back(w);
        rx_data  = fifo_q[0];
        rx_empty = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int k;
        k = 0;
        while (got.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (got.size() < n) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_bytes: got %0d bytes, expected %0d", got.size(), n);
        end
    endtask

    task automatic wait_valid(input int budget);
        int k;
        k = 0;
        while (!out_valid && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("wait_valid", {31'h0, out_valid}, 32'h1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        fifo_q.delete();
        rx_empty = 1'b1;
        wait_cycles(2);
        reset = 1'b1;
        wait_cycles(1);
        got.delete();
        strobe_cyc.delete();
        strobes = 0;
    endtask

    initial begin
        vecs[0] = '{10'h2A5, 8'h02, 8'hA5};
        vecs[1] = '{10'h000, 8'h00, 8'h00};
        vecs[2] = '{10'h155, 8'h01, 8'h55};
        vecs[3] = '{10'h3FF, 8'h03, 8'hFF};
        vecs[4] = '{10'h100, 8'h01, 8'h00};
        vecs[5] = '{10'h0FF, 8'h00, 8'hFF};

        reset     = 1'b0;
        rx_active = 1'b0;
        rx_error  = 1'b0;
        rx_data   = '0;
        rx_empty  = 1'b1;
        out_ready = 1'b1;
        wait_cycles(3);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_out_data", {24'h0, out_data}, 32'h0);
        check("rst_strobe", {31'h0, rx_read_strobe}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        reset = 1'b1;
        wait_cycles(2);
        check("rel_busy", {31'h0, busy}, 32'h0);

        // Single words with the host always ready.
        for (int i = 0; i < 6; i++) begin
            got.delete();
            strobes = 0;
            push_word(vecs[i].word);
            wait_bytes(2, 50);
            wait_cycles(3);
            check("vec_hi", byte_at(0), {24'h0, vecs[i].exp_hi});
            check("vec_lo", byte_at(1), {24'h0, vecs[i].exp_lo});
            check("vec_strobes", strobes, 1);
            check("vec_busy", {31'h0, busy}, 32'h0);
        end

        // Back-to-back words: pop spacing is 3 + SETTLE_CYCLES.
        got.delete();
        strobe_cyc.delete();
        push_word(10'h001);
        push_word(10'h302);
        wait_bytes(4, 50);
        wait_cycles(3);
        check("b2b_bytes", {byte_at(0)[7:0], byte_at(1)[7:0], byte_at(2)[7:0], byte_at(3)[7:0]},
              32'h0001_0302);
        check("b2b_spacing", (strobe_cyc.size() == 2) ? strobe_cyc[1] - strobe_cyc[0] : -1, 4);

        // Backpressure: header byte held stable, no extra pop.
        got.delete();
        strobes = 0;
        out_ready = 1'b0;
        push_word(10'h3FF);
        wait_valid(20);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {31'h0, out_valid}, 32'h1);
            check("bp_data", {24'h0, out_data}, 32'h03);
            @(negedge clk);
        end
        check("bp_strobes", strobes, 1);
        out_ready = 1'b1;
        wait_bytes(2, 20);
        wait_cycles(3);
        check("bp_hi", byte_at(0), 32'h03);
        check("bp_lo", byte_at(1), 32'hFF);
        check("bp_count", got.size(), 2);

        // Overflow error: one pair, no pop, hold until error clears.
        got.delete();
        strobes = 0;
        rx_error = 1'b1;
        rx_data  = ERROR_OVERFLOW;
        wait_bytes(2, 20);
        wait_cycles(10);
        check("err_hi", byte_at(0), 32'hC0);
        check("err_lo", byte_at(1), 32'h08);
        check("err_single", got.size(), 2);
        check("err_strobes", strobes, 0);
        check("err_wait_busy", {31'h0, busy}, 32'h1);
        rx_error = 1'b0;
        wait_cycles(3);
        check("err_idle", {31'h0, busy}, 32'h0);

        // Error raised during SEND_HI: data pair finishes first.
        got.delete();
        strobes = 0;
        out_ready = 1'b0;
        push_word(10'h155);
        wait_valid(20);
        wait_cycles(2);
        rx_error = 1'b1;
        rx_data  = 10'h208;
        wait_cycles(2);
        out_ready = 1'b1;
        wait_bytes(4, 30);
        check("mid_bytes", {byte_at(0)[7:0], byte_at(1)[7:0], byte_at(2)[7:0], byte_at(3)[7:0]},
              32'h0155_C208);
        check("mid_strobes", strobes, 1);
        rx_error = 1'b0;
        wait_cycles(3);
        check("mid_idle", {31'h0, busy}, 32'h0);

        // Asynchronous reset while the low byte is presented.
        got.delete();
        out_ready = 1'b0;
        push_word(10'h2A5);
        wait_valid(20);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("rs_lo_data", {24'h0, out_data}, 32'hA5);
        check("rs_lo_valid", {31'h0, out_valid}, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check("rs_async_valid", {31'h0, out_valid}, 32'h0);
        check("rs_async_busy", {31'h0, busy}, 32'h0);
        fifo_q.delete();
        rx_empty = 1'b1;
        wait_cycles(2);
        reset = 1'b1;
        wait_cycles(1);
        got.delete();
        out_ready = 1'b1;
        push_word(10'h155);
        wait_bytes(2, 20);
        check("rs_resume_hi", byte_at(0), 32'h01);
        check("rs_resume_lo", byte_at(1), 32'h55);

`ifdef COAX_RX_PACKER_EOM_EN
        // End of message after three words.
        do_reset();
        rx_active = 1'b1;
        wait_cycles(1);
        push_word(10'h011);
        push_word(10'h122);
        push_word(10'h233);
        wait_bytes(6, 60);
        rx_active = 1'b0;
        wait_bytes(8, 30);
        wait_cycles(3);
        check("eom3_data", {byte_at(0)[7:0], byte_at(1)[7:0], byte_at(4)[7:0], byte_at(5)[7:0]},
              32'h0011_0233);
        check("eom3_hi", byte_at(6), 32'h80);
        check("eom3_lo", byte_at(7), 32'h03);
        check("eom3_count", got.size(), 8);

        // 257 words wrap the 8-bit count; EOM deferred until the FIFO drains.
        got.delete();
        rx_active = 1'b1;
        wait_cycles(1);
        for (int i = 0; i < 257; i++) push_word(10'(i));
        wait_cycles(2);
        rx_active = 1'b0;
        wait_bytes(516, 2000);
        wait_cycles(3);
        check("eom257_last_data", {16'h0, byte_at(512)[7:0], byte_at(513)[7:0]}, 32'h0100);
        check("eom257_hi", byte_at(514), 32'h80);
        check("eom257_lo", byte_at(515), 32'h01);
        check("eom257_count", got.size(), 516);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/coax_rx_packer.md
Name: coax_rx_packer

Overview:
- Downstream consumer of the buffered coax receiver. Pops 10-bit received words from its FIFO and serialises each into a two-byte valid/ready stream for the host-side byte transport (SPI/UART bridge).
- Reports receiver errors as in-band error pairs.
- Optionally marks end-of-message when the line goes idle and the buffer has drained.

Parameters:
SETTLE_CYCLES, 1, cycles to wait after a pop before rx_empty/rx_data are sampled again (FIFO read latency).

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
rx_active  input  1  receiver active, from buffered receiver
rx_error  input  1  receiver error (sticky overflow or line error)
rx_data  input  10  FIFO head word, or error code when rx_error=1
rx_empty  input  1  FIFO empty
rx_read_strobe  output  1  one-cycle pop request to buffered receiver
out_data  output  8  byte to host
out_valid  output  1  out_data valid
out_ready  input  1  host accepts byte when out_valid && out_ready
busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset:
  - Single clock.
  - reset low asynchronously forces state IDLE and clears every register.
  - While reset is low and on release: out_data=0, out_valid=0, rx_read_strobe=0, busy=0, word_count=0, saw_active=0.
  - A reset mid-byte drops the pair; no partial resume.
- Byte formats:
  - Header byte: bit7=marker, bit6=error, bits5:2=0, bits1:0=payload[9:8].
  - Data pair: {8'h00 | data[9:8]}, data[7:0].
  - Error pair: {8'hC0 | code[9:8]}, code[7:0].
  - EOM pair: 8'h80, word_count[7:0].
- FSM states: IDLE, SEND_HI, SEND_LO, SETTLE, ERR_HI, ERR_LO, ERR_WAIT, EOM_HI, EOM_LO.
- IDLE, evaluated each cycle in priority order:
  1. rx_error=1: latch rx_data into err_reg, go to ERR_HI. Never strobe while rx_error.
  2. !rx_empty: latch rx_data into word_reg, assert rx_read_strobe this cycle only, word_count+1 (8-bit wrap), go to SEND_HI.
  3. saw_active && !rx_active: go to EOM_HI.
- saw_active:
  - Set on any cycle rx_active=1.
  - Cleared on acceptance of the EOM low byte.
- Byte transfer rules:
  - SEND_HI/SEND_LO, ERR_HI/ERR_LO, EOM_HI/EOM_LO each hold out_valid=1 with stable out_data until out_ready.
  - Acceptance advances the state one step.
  - out_data and out_valid are registered; a byte is presented the cycle after the state is entered.
  - Valid never drops without acceptance.
- After transfer:
  - SEND_LO accepted → SETTLE, held SETTLE_CYCLES cycles → IDLE.
  - ERR_LO accepted → ERR_WAIT, held until rx_error=0 → IDLE. Exactly one error pair per error episode.
  - EOM_LO accepted → IDLE, word_count cleared.
- Mid-pair events:
  - rx_error rising during SEND_*: current pair completes; error is handled on return to IDLE.
  - rx_active falling during a pair: EOM is deferred until the FIFO is empty.
- Throughput ceiling: one word per 3+SETTLE_CYCLES cycles with out_ready held high.

Optional Feature:
COAX_RX_PACKER_EOM_EN
- Defined: saw_active, word_count and the EOM_HI/EOM_LO states exist; EOM pairs are emitted as specified.
- Undefined: no EOM pairs; IDLE priority 3 is removed; word_count and saw_active are not synthesised. Stream carries only data and error pairs.

Decomposition:
- Shared package coax_pkg holds:
  - state enum for this FSM;
  - header constants HDR_DATA=8'h00, HDR_ERROR=8'hC0, HDR_EOM=8'h80;
  - ERROR_OVERFLOW=10'b0000001000, shared with the receiver.
- One natural sub-module: coax_byte_out, the registered valid/ready output holding register (load, hold-until-ready), reusable by the transmit-side host bridge.

Test Plan:
- FIFO holds 10'h2A5, out_ready=1 → one rx_read_strobe pulse, then bytes 8'h02, 8'hA5; busy returns to 0.
- Backpressure: FIFO holds 10'h3FF, out_ready=0 for 5 cycles → out_data=8'h03 held stable with out_valid=1 throughout; no second strobe; then 8'h03, 8'hFF.
- Overflow: rx_error=1, rx_data=10'h008 → pair 8'hC0, 8'h08; rx_read_strobe never asserts; stays in ERR_WAIT until rx_error=0.
- With COAX_RX_PACKER_EOM_EN: rx_active high, 3 words, rx_active low → three data pairs, then 8'h80, 8'h03. Repeat with 257 words → EOM low byte 8'h01.
- rx_error asserted during SEND_HI of word 10'h155 → 8'h01, 8'h55 complete first, then error pair.
- reset asserted while out_valid=1 in SEND_LO → out_valid=0 immediately (asynchronous); after release, next word starts with a high byte.
